jtag_mem_bridge: RTL and testbench



---
 rtl/jtag_mem_bridge.sv | 136 +++++++++++++
 tb/tb_jtag_mem_bridge.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_mem_bridge.sv
// Bridges JTAG debug-module memory accesses onto a req/gnt/rvalid bus master, one word per access.
// Optional `JTAG_BRIDGE_ALIGN_CHECK_EN rejects non-word-aligned addresses without touching the bus.
module jtag_mem_bridge #(
    parameter int ADDR_BITS      = 32,
    parameter int DATA_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dm_req_valid_i,
    output logic                 dm_req_ready_o,
    input  logic                 dm_we_i,
    input  logic [ADDR_BITS-1:0] dm_addr_i,
    input  logic [DATA_BITS-1:0] dm_wdata_i,
    output logic                 dm_resp_valid_o,
    input  logic                 dm_resp_ready_i,
    output logic [DATA_BITS-1:0] dm_rdata_o,
    output logic                 dm_resp_err_o,
    output logic                 hold_req_o,
    output logic                 m_req_o,
    output logic                 m_we_o,
    output logic [ADDR_BITS-1:0] m_addr_o,
    output logic [DATA_BITS-1:0] m_wdata_o,
    input  logic                 m_gnt_i,
    input  logic                 m_rvalid_i,
    input  logic [DATA_BITS-1:0] m_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    // TIMEOUT_CYCLES is expected in 1..65535 so the abort point fits the 16-bit counter
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic [15:0]            tmo_cnt;
    logic                   we_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [DATA_BITS-1:0]   wdata_q;
    logic                   misaligned;

`ifdef JTAG_BRIDGE_ALIGN_CHECK_EN
    assign misaligned = (dm_addr_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign m_we_o    = we_q;
    assign m_addr_o  = addr_q;
    assign m_wdata_o = wdata_q;

    // A completing bus event is tested before the timeout so it wins in the abort cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            tmo_cnt         <= '0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            dm_req_ready_o  <= 1'b1;
            dm_resp_valid_o <= 1'b0;
            dm_rdata_o      <= '0;
            dm_resp_err_o   <= 1'b0;
            hold_req_o      <= 1'b0;
            m_req_o         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_req_valid_i) begin
                        we_q           <= dm_we_i;
                        addr_q         <= dm_addr_i;
                        wdata_q        <= dm_wdata_i;
                        tmo_cnt        <= '0;
                        dm_req_ready_o <= 1'b0;
                        hold_req_o     <= 1'b1;
                        if (misaligned) begin
                            state           <= RESP;
                            dm_resp_valid_o <= 1'b1;
                            dm_resp_err_o   <= 1'b1;
                            dm_rdata_o      <= '0;
                        end else begin
                            state   <= REQ;
                            m_req_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (m_gnt_i && m_rvalid_i) begin
                        state           <= RESP;
                        m_req_o         <= 1'b0;
                        dm_resp_valid_o <= 1'b1;
                        dm_resp_err_o   <= 1'b0;
                        dm_rdata_o      <= we_q ? '0 : m_rdata_i;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state           <= RESP;
                        m_req_o         <= 1'b0;
                        dm_resp_valid_o <= 1'b1;
                        dm_resp_err_o   <= 1'b1;
                        dm_rdata_o      <= '0;
                    end else if (m_gnt_i) begin
                        state   <= WAIT;
                        m_req_o <= 1'b0;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (m_rvalid_i) begin
                        state           <= RESP;
                        dm_resp_valid_o <= 1'b1;
                        dm_resp_err_o   <= 1'b0;
                        dm_rdata_o      <= we_q ? '0 : m_rdata_i;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state           <= RESP;
                        dm_resp_valid_o <= 1'b1;
                        dm_resp_err_o   <= 1'b1;
                        dm_rdata_o      <= '0;
                    end
                end
                RESP: begin
                    if (dm_resp_ready_i) begin
                        state           <= IDLE;
                        dm_resp_valid_o <= 1'b0;
                        dm_resp_err_o   <= 1'b0;
                        dm_rdata_o      <= '0;
                        hold_req_o      <= 1'b0;
                        dm_req_ready_o  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Randomized self-checking bench for jtag_mem_bridge; the model predicts each access outcome
// from the grant/response delays and the timeout budget, honouring `JTAG_BRIDGE_ALIGN_CHECK_EN.
module tb_jtag_mem_bridge;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dm_req_valid_i;
    logic        dm_req_ready_o;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        dm_resp_valid_o;
    logic        dm_resp_ready_i;
    logic [31:0] dm_rdata_o;
    logic        dm_resp_err_o;
    logic        hold_req_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic        m_gnt_i;
    logic        m_rvalid_i;
    logic [31:0] m_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    jtag_mem_bridge #(
        .ADDR_BITS(32),
        .DATA_BITS(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dm_req_valid_i(dm_req_valid_i),
        .dm_req_ready_o(dm_req_ready_o),
        .dm_we_i(dm_we_i),
        .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i),
        .dm_resp_valid_o(dm_resp_valid_o),
        .dm_resp_ready_i(dm_resp_ready_i),
        .dm_rdata_o(dm_rdata_o),
        .dm_resp_err_o(dm_resp_err_o),
        .hold_req_o(hold_req_o),
        .m_req_o(m_req_o),
        .m_we_o(m_we_o),
        .m_addr_o(m_addr_o),
        .m_wdata_o(m_wdata_o),
        .m_gnt_i(m_gnt_i),
        .m_rvalid_i(m_rvalid_i),
        .m_rdata_i(m_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge; g = grant delay, r = rvalid delay after grant
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int g, input int r, input int hold);
        int          done;
        int          last_req;
        logic        ok;
        logic [31:0] exp_rd;
        done     = g + r;
        ok       = (done <= T - 1);
        if (!ok) done = T - 1;
        last_req = (g < T - 1) ? g : T - 1;
        exp_rd   = (ok && !we) ? rdata : 32'h0;

        dm_req_valid_i  = 1'b1;
        dm_we_i         = we;
        dm_addr_i       = addr;
        dm_wdata_i      = wdata;
        dm_resp_ready_i = 1'b0;
        @(negedge clk);
        check("req_ready_idle", dm_req_ready_o, 1'b1);
        check("hold_idle", hold_req_o, 1'b0);
        check("resp_valid_idle", dm_resp_valid_o, 1'b0);
        check("m_req_idle", m_req_o, 1'b0);

        for (int i = 0; i <= done + 1; i++) begin
            @(posedge clk); #1;
            dm_req_valid_i = 1'b0;
            dm_we_i        = 1'($urandom);
            dm_addr_i      = $urandom;
            dm_wdata_i     = $urandom;
            m_gnt_i        = (i == g);
            m_rvalid_i     = (i == g + r) || (i < g && ($urandom % 2 == 1));
            m_rdata_i      = (i == g + r) ? rdata : $urandom;
            @(negedge clk);
            check("m_req", m_req_o, (i <= last_req));
            if (i <= last_req) begin
                check("m_we", m_we_o, we);
                check("m_addr", m_addr_o, addr);
                check("m_wdata", m_wdata_o, wdata);
            end
            check("resp_valid_timing", dm_resp_valid_o, (i == done + 1));
            check("hold_busy", hold_req_o, 1'b1);
            check("req_ready_busy", dm_req_ready_o, 1'b0);
        end
        check("resp_rdata", dm_rdata_o, exp_rd);
        check("resp_err", dm_resp_err_o, !ok);

        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            m_gnt_i    = 1'($urandom);
            m_rvalid_i = 1'b1;
            m_rdata_i  = $urandom;
            @(negedge clk);
            check("stall_valid", dm_resp_valid_o, 1'b1);
            check("stall_rdata", dm_rdata_o, exp_rd);
            check("stall_err", dm_resp_err_o, !ok);
            check("stall_req_ready", dm_req_ready_o, 1'b0);
            check("stall_m_req", m_req_o, 1'b0);
        end

        @(posedge clk); #1;
        m_gnt_i         = 1'b0;
        m_rvalid_i      = 1'b0;
        dm_resp_ready_i = 1'b1;
        @(posedge clk); #1;
        dm_resp_ready_i = 1'b0;
    endtask

    // Reset asserted mid-access, either still in REQ or after the grant in WAIT
    task automatic abort_test(input logic go_wait);
        dm_req_valid_i = 1'b1;
        dm_we_i        = 1'b0;
        dm_addr_i      = 32'h40;
        @(posedge clk); #1;
        dm_req_valid_i = 1'b0;
        m_gnt_i        = go_wait;
        if (go_wait) begin
            @(posedge clk); #1;
            m_gnt_i = 1'b0;
        end
        #1;
        check("pre_rst_m_req", m_req_o, !go_wait);
        check("pre_rst_hold", hold_req_o, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst_m_req", m_req_o, 1'b0);
        check("rst_hold", hold_req_o, 1'b0);
        check("rst_req_ready", dm_req_ready_o, 1'b1);
        check("rst_resp_valid", dm_resp_valid_o, 1'b0);
        check("rst_m_addr", m_addr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst             = 1'b1;
        dm_req_valid_i  = 1'b0;
        dm_we_i         = 1'b0;
        dm_addr_i       = '0;
        dm_wdata_i      = '0;
        dm_resp_ready_i = 1'b0;
        m_gnt_i         = 1'b0;
        m_rvalid_i      = 1'b0;
        m_rdata_i       = '0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", dm_req_ready_o, 1'b1);
        check("reset_resp_valid", dm_resp_valid_o, 1'b0);
        check("reset_hold", hold_req_o, 1'b0);
        check("reset_m_req", m_req_o, 1'b0);
        check("reset_rdata", dm_rdata_o, 32'h0);
        check("reset_err", dm_resp_err_o, 1'b0);
        check("reset_m_fields", {m_we_o, m_addr_o, m_wdata_o}, 65'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases: plain read, single-cycle write, timeout, long stall
        do_access(1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 2, 0);
        do_access(1'b1, 32'h20, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 0);
        do_access(1'b0, 32'h300, 32'h0, 32'hA5A5_A5A5, 100, 0, 3);
        do_access(1'b0, 32'h304, 32'h0, 32'h0BAD_F00D, 1, 1, 5);
        do_access(1'b0, 32'h308, 32'h0, 32'h1111_2222, 3, 0, 0);
        do_access(1'b0, 32'h30C, 32'h0, 32'h3333_4444, 3, 1, 0);

        abort_test(1'b1);
        do_access(1'b0, 32'h44, 32'h0, 32'hCAFE_0001, 1, 1, 0);
        abort_test(1'b0);
        do_access(1'b1, 32'h48, 32'h5555_AAAA, 32'h0, 0, 1, 1);

`ifdef JTAG_BRIDGE_ALIGN_CHECK_EN
        dm_req_valid_i = 1'b1;
        dm_we_i        = 1'b0;
        dm_addr_i      = 32'h1002;
        @(negedge clk);
        check("align_req_ready", dm_req_ready_o, 1'b1);
        @(posedge clk); #1;
        dm_req_valid_i = 1'b0;
        @(negedge clk);
        check("align_no_m_req", m_req_o, 1'b0);
        check("align_resp_valid", dm_resp_valid_o, 1'b1);
        check("align_err", dm_resp_err_o, 1'b1);
        check("align_rdata", dm_rdata_o, 32'h0);
        check("align_hold", hold_req_o, 1'b1);
        @(posedge clk); #1;
        dm_resp_ready_i = 1'b1;
        @(posedge clk); #1;
        dm_resp_ready_i = 1'b0;
`else
        do_access(1'b0, 32'h1002, 32'h0, 32'h7777_8888, 1, 0, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            do_access(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
